cv32e40p_err_counter_bank_ft: RTL and testbench

//  Parametrised bank of leaky-bucket error counters for N redundant functional units (ALU/MULT copies)
//  x M operation classes. Each (unit,class) counter rises on a detected voter mismatch and decays on a clean op.

---
 rtl/cv32e40p_err_counter_bank_ft.sv | 146 ++++++++++++++
 tb/tb_cv32e40p_err_counter_bank_ft.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_err_counter_bank_ft.sv
// rtl/cv32e40p_err_counter_bank_ft.sv - leaky-bucket error counter bank with sticky fault map
//
// Purpose: one saturating up/down counter per (unit, class) pair of the redundant
// execution units. Voter mismatches push a counter up by INC, clean ops let it
// leak down by DEC. Hitting THRESHOLD marks the pair permanently faulty (sticky)
// and pulses fault_new_o. Counters and the fault map are CSR read/write.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   ev_valid_i[u]     unit u finished a voted op this cycle
//   ev_class_i        per-unit op class, unit u in bits [u*CLS_W +: CLS_W]
//   ev_error_i[u]     voter flagged unit u's result as wrong
//   faulty_o[k]       sticky fault bit, k = u*N_CLASSES + c
//   fault_new_o       one-cycle pulse when a fault bit is set by threshold
//   csr_*             CSR access; counter k at CSR_BASE+k, fault map at CSR_BASE+NK
module cv32e40p_err_counter_bank_ft #(
    parameter int          N_UNITS   = 3,
    parameter int          N_CLASSES = 4,
    parameter int          CNT_W     = 16,
    parameter int          THRESHOLD = 64,
    parameter int          INC       = 4,
    parameter int          DEC       = 1,
    parameter logic [11:0] CSR_BASE  = 12'h7C0,
    localparam int         CLS_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1,
    localparam int         NK        = N_UNITS * N_CLASSES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_UNITS-1:0]       ev_valid_i,
    input  logic [N_UNITS*CLS_W-1:0] ev_class_i,
    input  logic [N_UNITS-1:0]       ev_error_i,
    output logic [NK-1:0]            faulty_o,
    output logic                     fault_new_o,
    input  logic [11:0]              csr_addr_i,
    input  logic                     csr_re_i,
    input  logic                     csr_we_i,
    input  logic [31:0]              csr_wdata_i,
    output logic [31:0]              csr_rdata_o,
    output logic                     csr_hit_o
);

    localparam logic [CNT_W-1:0] THR_V   = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] DEC_V   = CNT_W'(DEC);
    localparam logic [CNT_W:0]   INC_X   = (CNT_W+1)'(INC);
    localparam logic [CNT_W:0]   THR_X   = (CNT_W+1)'(THRESHOLD);

    logic [CNT_W-1:0] cnt_q [NK];
    logic [CNT_W-1:0] cnt_d [NK];
    logic [NK-1:0]    faulty_q, faulty_d;
    logic             fault_new_q, fault_new_d;

    // Decode in 13 bits so CSR_BASE+NK cannot wrap past 12'hFFF.
    logic [12:0] addr_x;
    logic [11:0] csr_idx;
    logic        csr_hit;
    logic        wr_cnt, wr_map;
    logic        unused_wdata;

    assign addr_x  = {1'b0, csr_addr_i};
    assign csr_hit = (addr_x >= {1'b0, CSR_BASE}) && (addr_x <= ({1'b0, CSR_BASE} + 13'(NK)));
    assign csr_idx = csr_addr_i - CSR_BASE;
    assign wr_cnt  = csr_we_i && csr_hit && (int'(csr_idx) < NK);
    assign wr_map  = csr_we_i && csr_hit && (int'(csr_idx) == NK);
    assign unused_wdata = ^csr_wdata_i;

    always_comb begin
        logic [CLS_W-1:0] cls;
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] nxt;
        int               k;
        cls         = '0;
        sum         = '0;
        nxt         = '0;
        k           = 0;
        cnt_d       = cnt_q;
        faulty_d    = faulty_q;
        fault_new_d = 1'b0;

        for (int u = 0; u < N_UNITS; u++) begin
            cls = ev_class_i[u*CLS_W +: CLS_W];
            if (ev_valid_i[u] && (int'(cls) < N_CLASSES)) begin
                k = u * N_CLASSES + int'(cls);
                // A map write touches every bit, so it pre-empts all events;
                // a counter write only pre-empts the event aimed at that counter.
                if (!faulty_q[k] && !wr_map && !(wr_cnt && (int'(csr_idx) == k))) begin
                    if (ev_error_i[u]) begin
                        sum = {1'b0, cnt_q[k]} + INC_X;
                        nxt = (sum >= THR_X) ? THR_V : sum[CNT_W-1:0];
                    end else begin
                        nxt = (cnt_q[k] >= DEC_V) ? (cnt_q[k] - DEC_V) : '0;
                    end
                    cnt_d[k] = nxt;
                    if (nxt == THR_V) begin
                        faulty_d[k] = 1'b1;
                        fault_new_d = 1'b1;
                    end
                end
            end
        end

        // Software writes never raise faults: they only clamp, preload or clear.
        if (wr_cnt) begin
            for (int j = 0; j < NK; j++) begin
                if (int'(csr_idx) == j) begin
                    cnt_d[j] = (csr_wdata_i[CNT_W-1:0] >= THR_V) ? THR_V : csr_wdata_i[CNT_W-1:0];
                end
            end
        end
        if (wr_map) begin
            faulty_d = csr_wdata_i[NK-1:0];
            for (int j = 0; j < NK; j++) begin
                if (!csr_wdata_i[j]) cnt_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NK; j++) cnt_q[j] <= '0;
            faulty_q    <= '0;
            fault_new_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            faulty_q    <= faulty_d;
            fault_new_q <= fault_new_d;
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        if (csr_re_i && csr_hit) begin
            if (int'(csr_idx) == NK) begin
                csr_rdata_o = 32'(faulty_q);
            end else begin
                for (int j = 0; j < NK; j++) begin
                    if (int'(csr_idx) == j) csr_rdata_o = 32'(cnt_q[j]);
                end
            end
        end
    end

    assign csr_hit_o   = csr_hit;
    assign faulty_o    = faulty_q;
    assign fault_new_o = fault_new_q;

endmodule

// File: tb/tb_cv32e40p_err_counter_bank_ft.sv
// tb/tb_cv32e40p_err_counter_bank_ft.sv - scoreboard bench for the error counter bank
module tb_cv32e40p_err_counter_bank_ft;

    localparam logic [11:0] BASE = 12'h7C0;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ev_valid;
    logic [5:0]  ev_class;
    logic [2:0]  ev_error;
    logic [11:0] faulty;
    logic        fault_new;
    logic [11:0] csr_addr;
    logic        csr_re, csr_we;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_hit;

    // Second instance with 3 classes so an out-of-range class is encodable.
    logic [1:0]  ev_valid3, ev_error3;
    logic [3:0]  ev_class3;
    logic [5:0]  faulty3;
    logic        fault_new3;
    logic [11:0] csr_addr3;
    logic        csr_re3;
    logic [31:0] csr_rdata3;
    logic        csr_hit3;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    always @(negedge clk) if (fault_new) pulse_cnt++;

    cv32e40p_err_counter_bank_ft dut (
        .clk(clk), .rst(rst), .ev_valid_i(ev_valid), .ev_class_i(ev_class), .ev_error_i(ev_error),
        .faulty_o(faulty), .fault_new_o(fault_new), .csr_addr_i(csr_addr), .csr_re_i(csr_re),
        .csr_we_i(csr_we), .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_hit_o(csr_hit)
    );

    cv32e40p_err_counter_bank_ft #(.N_UNITS(2), .N_CLASSES(3)) dut3 (
        .clk(clk), .rst(rst), .ev_valid_i(ev_valid3), .ev_class_i(ev_class3), .ev_error_i(ev_error3),
        .faulty_o(faulty3), .fault_new_o(fault_new3), .csr_addr_i(csr_addr3), .csr_re_i(csr_re3),
        .csr_we_i(1'b0), .csr_wdata_i(32'h0), .csr_rdata_o(csr_rdata3), .csr_hit_o(csr_hit3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev_clear();
        ev_valid = '0; ev_class = '0; ev_error = '0;
    endtask

    task automatic ev_set(input int u, input int c, input bit e);
        logic [1:0] c2;
        c2 = c[1:0];
        ev_valid[u] = 1'b1;
        ev_class[u*2 +: 2] = c2;
        ev_error[u] = e;
    endtask

    task automatic ev_one(input int u, input int c, input bit e);
        ev_set(u, c, e);
        tick();
        ev_clear();
    endtask

    task automatic csr_write(input int idx, input logic [31:0] d);
        csr_addr = BASE + 12'(idx); csr_wdata = d; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input int idx, output logic [31:0] d, output logic h);
        csr_addr = BASE + 12'(idx); csr_re = 1'b1;
        #1;
        d = csr_rdata; h = csr_hit;
        csr_re = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d, e; logic h;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (faulty !== 12'h0) begin errors++; $display("FAIL reset_faulty got %h exp 0", faulty); end
        checks++;
        if (fault_new !== 1'b0) begin errors++; $display("FAIL reset_fault_new got %b exp 0", fault_new); end
        for (int k = 0; k <= 12; k++) exp_q.push_back(32'h0);
        for (int k = 0; k <= 12; k++) begin
            csr_read(k, d, h);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL reset_read[%0d] got %h exp %h", k, d, e); end
        end
        checks++;
        if (pulse_cnt !== 0) begin errors++; $display("FAIL reset_pulses got %0d exp 0", pulse_cnt); end
    endtask

    task automatic test_ramp();
        logic [31:0] d, e; logic h; int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 15; i++) ev_one(1, 2, 1'b1);
        exp_q.push_back(32'd60);
        csr_read(6, d, h);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL ramp_cnt15 got %0d exp %0d", d, e); end
        checks++;
        if (faulty !== 12'h0) begin errors++; $display("FAIL ramp_early_fault got %h exp 0", faulty); end
        ev_one(1, 2, 1'b1);
        checks++;
        if (faulty !== 12'h040 || fault_new !== 1'b1) begin
            errors++; $display("FAIL ramp_trip faulty %h new %b exp 040 1", faulty, fault_new);
        end
        tick();
        checks++;
        if (fault_new !== 1'b0) begin errors++; $display("FAIL ramp_pulse_width got %b exp 0", fault_new); end
        for (int i = 0; i < 3; i++) ev_one(1, 2, 1'b1);
        exp_q.push_back(32'd64);
        csr_read(6, d, h);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL ramp_sat got %0d exp %0d", d, e); end
        checks++;
        if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL ramp_pulses got %0d exp 1", pulse_cnt - p0); end
    endtask

    task automatic test_map_clear();
        logic [31:0] d, e; logic h;
        csr_write(12, 32'h0);
        checks++;
        if (faulty !== 12'h0) begin errors++; $display("FAIL map_clear_faulty got %h exp 0", faulty); end
        exp_q.push_back(32'd0);
        csr_read(6, d, h);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL map_clear_cnt got %0d exp %0d", d, e); end
        ev_one(1, 2, 1'b1);
        exp_q.push_back(32'd4);
        csr_read(6, d, h);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL map_clear_reerr got %0d exp %0d", d, e); end
    endtask

    task automatic test_decay();
        logic [31:0] d, e; logic h;
        csr_write(0, 32'd2);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        for (int i = 0; i < 3; i++) begin
            ev_one(0, 0, 1'b0);
            csr_read(0, d, h);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL decay[%0d] got %0d exp %0d", i, d, e); end
        end
    endtask

    task automatic test_collision();
        logic [31:0] d, e;
        csr_addr = BASE + 12'd5; csr_wdata = 32'd5; csr_we = 1'b1; csr_re = 1'b1;
        ev_set(1, 1, 1'b1);
        ev_set(0, 3, 1'b1);
        exp_q.push_back(32'd0);
        #1;
        d = csr_rdata;
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL coll_pre_edge_read got %0d exp %0d", d, e); end
        tick();
        csr_we = 1'b0; csr_re = 1'b0;
        ev_clear();
        exp_q.push_back(32'd5); exp_q.push_back(32'd4);
        begin
            logic h;
            csr_read(5, d, h);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL coll_cnt5 got %0d exp %0d", d, e); end
            csr_read(3, d, h);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL coll_other got %0d exp %0d", d, e); end
        end
    endtask

    task automatic test_write_threshold();
        logic [31:0] d, e; logic h; int p0;
        p0 = pulse_cnt;
        csr_write(0, 32'd100);
        tick();
        exp_q.push_back(32'd64);
        csr_read(0, d, h);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL wr_clamp got %0d exp %0d", d, e); end
        checks++;
        if (faulty !== 12'h0 || pulse_cnt !== p0) begin
            errors++; $display("FAIL wr_no_fault faulty %h pulses %0d exp 0 0", faulty, pulse_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e; logic h;
        ev_set(0, 1, 1'b1); ev_set(1, 0, 1'b1); ev_set(2, 3, 1'b1);
        tick();
        ev_set(0, 1, 1'b1); ev_set(1, 0, 1'b0); ev_set(2, 3, 1'b1);
        tick();
        ev_clear();
        exp_q.push_back(32'd8); exp_q.push_back(32'd3); exp_q.push_back(32'd8);
        csr_read(1, d, h);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL b2b_u0c1 got %0d exp %0d", d, e); end
        csr_read(4, d, h);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL b2b_u1c0 got %0d exp %0d", d, e); end
        csr_read(11, d, h);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL b2b_u2c3 got %0d exp %0d", d, e); end
    endtask

    task automatic test_decode();
        logic [31:0] d; logic h;
        csr_read(13, d, h);
        checks++;
        if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL dec_above hit %b data %h exp 0 0", h, d); end
        csr_read(-1, d, h);
        checks++;
        if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL dec_below hit %b data %h exp 0 0", h, d); end
        csr_write(12, 32'h0000_0801);
        csr_read(12, d, h);
        checks++;
        if (h !== 1'b1 || d !== 32'h801) begin errors++; $display("FAIL dec_map hit %b data %h exp 1 801", h, d); end
        csr_addr = BASE + 12'd12; csr_re = 1'b0;
        #1;
        checks++;
        if (csr_rdata !== 32'h0 || csr_hit !== 1'b1) begin
            errors++; $display("FAIL dec_re0 data %h hit %b exp 0 1", csr_rdata, csr_hit);
        end
        // Out-of-range class on the 3-class instance must leave every counter untouched.
        ev_valid3 = 2'b11; ev_class3 = 4'b1111; ev_error3 = 2'b11;
        tick();
        ev_valid3 = '0; ev_error3 = '0; ev_class3 = '0;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(32'h0);
            csr_addr3 = BASE + 12'(k); csr_re3 = 1'b1;
            #1;
            d = exp_q.pop_front();
            checks++;
            if (csr_rdata3 !== d) begin errors++; $display("FAIL dec_badclass[%0d] got %h exp %h", k, csr_rdata3, d); end
            csr_re3 = 1'b0;
        end
        checks++;
        if (faulty3 !== 6'h0) begin errors++; $display("FAIL dec_badclass_fault got %h exp 0", faulty3); end
    endtask

    task automatic test_midreset();
        logic [31:0] d, e; logic h;
        csr_write(12, 32'h0);
        for (int i = 0; i < 10; i++) ev_one(2, 1, 1'b1);
        exp_q.push_back(32'd40);
        csr_read(9, d, h);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL mid_pre got %0d exp %0d", d, e); end
        csr_write(12, 32'h0000_0400);
        rst = 1'b1;
        ev_set(2, 1, 1'b1);
        tick();
        rst = 1'b0;
        ev_clear();
        checks++;
        if (faulty !== 12'h0) begin errors++; $display("FAIL mid_faulty got %h exp 0", faulty); end
        for (int k = 0; k < 12; k++) exp_q.push_back(32'h0);
        for (int k = 0; k < 12; k++) begin
            csr_read(k, d, h);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin errors++; $display("FAIL mid_cnt[%0d] got %0d exp %0d", k, d, e); end
        end
    endtask

    initial begin
        rst = 1'b1; ev_clear();
        csr_addr = '0; csr_re = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        ev_valid3 = '0; ev_class3 = '0; ev_error3 = '0; csr_addr3 = '0; csr_re3 = 1'b0;
        test_reset();
        test_ramp();
        test_map_clear();
        test_decay();
        test_collision();
        test_write_threshold();
        test_back_to_back();
        test_decode();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
